// File: rtl/retire_multi.sv
// retire_multi: N-wide in-order retire stage with a private reorder buffer.
//   - Rename allocates one entry per cycle at the tail. The tail index is the ROB tag.
//   - Writeback marks an allocated entry DONE and stores its dest/value.
//   - Each cycle, up to RETIRE_WIDTH of the oldest consecutive DONE entries leave at the head.
//   - Retire outputs are registered and appear one cycle after the head advances.
//   - flush empties the buffer. rst does the same and also clears the retire outputs and counters.
// Slot 0 is never allocated, because tag 0 means "no ROB tag". Pointers wrap from ROB_DEPTH-1 back to 1.
// Optional feature: define QU_RETIRE_PERF_CNT_EN to build the saturating perf counters.
// Without it, both perf ports read 0.
module retire_multi #(
    parameter int ROB_DEPTH         = 16,
    parameter int RETIRE_WIDTH      = 2,
    parameter int PHY_RF_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH        = 32,
    localparam int AW               = $clog2(ROB_DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   alloc_en,
    output logic [AW-1:0]                          alloc_rob_addr,
    output logic                                   rob_full,
    output logic                                   rob_empty,
    input  logic                                   cmp_en,
    input  logic [AW-1:0]                          cmp_rob_addr,
    input  logic [PHY_RF_ADDR_WIDTH-1:0]           cmp_dest,
    input  logic [DATA_WIDTH-1:0]                  cmp_value,
    output logic [RETIRE_WIDTH-1:0]                ret_en,
    output logic [RETIRE_WIDTH*PHY_RF_ADDR_WIDTH-1:0] ret_dest,
    output logic [RETIRE_WIDTH*AW-1:0]             ret_rob_addr,
    output logic [RETIRE_WIDTH*DATA_WIDTH-1:0]     ret_value,
    output logic [63:0]                            perf_retired_cnt,
    output logic [31:0]                            perf_stall_cnt
);

    localparam int NRW = $clog2(RETIRE_WIDTH + 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(ROB_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_DONE  = 2'd2
    } entry_state_t;

    // ROB storage
    entry_state_t                  state_q [ROB_DEPTH];
    entry_state_t                  state_d [ROB_DEPTH];
    logic [PHY_RF_ADDR_WIDTH-1:0]  dest_q  [ROB_DEPTH];
    logic [PHY_RF_ADDR_WIDTH-1:0]  dest_d  [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]         value_q [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]         value_d [ROB_DEPTH];

    // Pointers and occupancy
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] count_q, count_d;

    // Registered retire lanes
    logic [RETIRE_WIDTH-1:0]       ret_en_q, ret_en_d;
    logic [PHY_RF_ADDR_WIDTH-1:0]  ret_dest_q  [RETIRE_WIDTH];
    logic [PHY_RF_ADDR_WIDTH-1:0]  ret_dest_d  [RETIRE_WIDTH];
    logic [AW-1:0]                 ret_addr_q  [RETIRE_WIDTH];
    logic [AW-1:0]                 ret_addr_d  [RETIRE_WIDTH];
    logic [DATA_WIDTH-1:0]         ret_value_q [RETIRE_WIDTH];
    logic [DATA_WIDTH-1:0]         ret_value_d [RETIRE_WIDTH];

    // Retire selection
    logic [AW-1:0]           lane_idx [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0] lane_ret;
    logic [NRW-1:0]          nret;
    logic                    lane_chain;
    logic                    alloc_ok;

    // Advance a ROB index by step, wrapping ROB_DEPTH-1 -> 1 and never landing on slot 0.
    function automatic logic [AW-1:0] rob_advance(input logic [AW-1:0] base,
                                                  input logic [AW:0]   step);
        logic [AW:0] sum;
        sum = {1'b0, base} + step;
        if (sum > (AW+1)'(ROB_DEPTH - 1)) begin
            sum = sum - (AW+1)'(ROB_DEPTH - 1);
        end
        return sum[AW-1:0];
    endfunction

    assign alloc_rob_addr = tail_q;
    assign rob_full       = (count_q == LAST_IDX);
    assign rob_empty      = (count_q == '0);

    // Lane k retires head+k only while every older lane also retires (oldest-first prefix).
    always_comb begin
        lane_ret   = '0;
        nret       = '0;
        lane_chain = 1'b1;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            lane_idx[k] = rob_advance(head_q, (AW+1)'(k));
            if (lane_chain && (state_q[lane_idx[k]] == ST_DONE)) begin
                lane_ret[k] = 1'b1;
                nret        = nret + NRW'(1);
            end else begin
                lane_chain = 1'b0;
            end
        end
    end

    // A full ROB can still accept an allocation when the head slot is freed in the same cycle.
    assign alloc_ok = alloc_en && (!rob_full || (nret != '0));

    // Next state: flush wins. Otherwise apply retire frees, then writeback, then allocation.
    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        value_d  = value_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        ret_en_d = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            ret_dest_d[k]  = '0;
            ret_addr_d[k]  = '0;
            ret_value_d[k] = '0;
        end

        if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                state_d[i] = ST_FREE;
            end
            head_d  = FIRST_IDX;
            tail_d  = FIRST_IDX;
            count_d = '0;
        end else begin
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (lane_ret[k]) begin
                    state_d[lane_idx[k]] = ST_FREE;
                    ret_en_d[k]          = 1'b1;
                    ret_dest_d[k]        = dest_q[lane_idx[k]];
                    ret_addr_d[k]        = lane_idx[k];
                    ret_value_d[k]       = value_q[lane_idx[k]];
                end
            end

            // Writebacks to FREE or already-DONE entries are dropped.
            if (cmp_en && (state_q[cmp_rob_addr] == ST_ALLOC)) begin
                state_d[cmp_rob_addr] = ST_DONE;
                dest_d[cmp_rob_addr]  = cmp_dest;
                value_d[cmp_rob_addr] = cmp_value;
            end

            if (alloc_ok) begin
                state_d[tail_q] = ST_ALLOC;
                tail_d          = rob_advance(tail_q, (AW+1)'(1));
            end

            head_d  = rob_advance(head_q, (AW+1)'(nret));
            count_d = count_q + AW'(alloc_ok) - AW'(nret);
        end
    end

    // Control state: entry states, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                state_q[i] <= ST_FREE;
            end
            head_q  <= FIRST_IDX;
            tail_q  <= FIRST_IDX;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage. It needs no reset because it is only read behind a DONE state.
    always_ff @(posedge clk) begin
        dest_q  <= dest_d;
        value_q <= value_d;
    end

    // Registered retire lanes. These feed the RF write, the busy clear and the RS broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_en_q <= '0;
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                ret_dest_q[k]  <= '0;
                ret_addr_q[k]  <= '0;
                ret_value_q[k] <= '0;
            end
        end else begin
            ret_en_q    <= ret_en_d;
            ret_dest_q  <= ret_dest_d;
            ret_addr_q  <= ret_addr_d;
            ret_value_q <= ret_value_d;
        end
    end

    assign ret_en = ret_en_q;

    // Pack lanes so that lane 0 (the oldest) sits in the least significant slice.
    genvar gi;
    generate
        for (gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_lane
            assign ret_dest[gi*PHY_RF_ADDR_WIDTH +: PHY_RF_ADDR_WIDTH] = ret_dest_q[gi];
            assign ret_rob_addr[gi*AW +: AW]                           = ret_addr_q[gi];
            assign ret_value[gi*DATA_WIDTH +: DATA_WIDTH]              = ret_value_q[gi];
        end
    endgenerate

`ifdef QU_RETIRE_PERF_CNT_EN
    logic [63:0] perf_ret_q, perf_ret_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [64:0] perf_ret_sum;

    // Saturating counters. A flush cycle retires nothing, so the counters hold during it.
    always_comb begin
        perf_ret_d   = perf_ret_q;
        perf_stall_d = perf_stall_q;
        perf_ret_sum = {1'b0, perf_ret_q} + 65'(nret);
        if (!flush) begin
            perf_ret_d = perf_ret_sum[64] ? '1 : perf_ret_sum[63:0];
            if (!rob_empty && (nret == '0) && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    // Only rst clears the counters. A flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ret_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ret_q   <= perf_ret_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_retired_cnt = perf_ret_q;
    assign perf_stall_cnt   = perf_stall_q;
`else
    assign perf_retired_cnt = '0;
    assign perf_stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_retire_multi.sv
// tb_retire_multi: directed scenarios plus randomized traffic against a queue-based ROB model.
// The model keeps the in-flight entries as an age-ordered queue.
// Each edge it pops the leading DONE entries, up to the retire width.
// Build with QU_RETIRE_PERF_CNT_EN defined to also check the perf counters against the model.
module tb_retire_multi;

    localparam int W  = 2;
    localparam int D  = 16;
    localparam int P  = 6;
    localparam int DW = 32;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              rst, flush, alloc_en, cmp_en;
    logic [AW-1:0]     alloc_rob_addr, cmp_rob_addr;
    logic              rob_full, rob_empty;
    logic [P-1:0]      cmp_dest;
    logic [DW-1:0]     cmp_value;
    logic [W-1:0]      ret_en;
    logic [W*P-1:0]    ret_dest;
    logic [W*AW-1:0]   ret_rob_addr;
    logic [W*DW-1:0]   ret_value;
    logic [63:0]       perf_retired_cnt;
    logic [31:0]       perf_stall_cnt;

    retire_multi #(
        .ROB_DEPTH(D), .RETIRE_WIDTH(W), .PHY_RF_ADDR_WIDTH(P), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .alloc_en(alloc_en),
        .alloc_rob_addr(alloc_rob_addr), .rob_full(rob_full), .rob_empty(rob_empty),
        .cmp_en(cmp_en), .cmp_rob_addr(cmp_rob_addr), .cmp_dest(cmp_dest), .cmp_value(cmp_value),
        .ret_en(ret_en), .ret_dest(ret_dest), .ret_rob_addr(ret_rob_addr), .ret_value(ret_value),
        .perf_retired_cnt(perf_retired_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the age-ordered in-flight entries and the expected registered outputs.
    typedef struct {
        logic [AW-1:0] tag;
        bit            done;
        logic [P-1:0]  dest;
        logic [DW-1:0] val;
    } ent_t;

    ent_t            mq[$];
    logic [AW-1:0]   m_tail;
    logic [W-1:0]    x_en;
    logic [W*P-1:0]  x_dest;
    logic [W*AW-1:0] x_addr;
    logic [W*DW-1:0] x_val;
    longint unsigned m_pret;
    int unsigned     m_pstall;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge to the model, using the inputs as driven before the edge.
    task automatic model_edge();
        int   n;
        bit   was_full;
        ent_t e;
        if (rst || flush) begin
            mq.delete();
            m_tail = 1;
            x_en   = '0;
            if (rst) begin
                x_dest   = '0;
                x_addr   = '0;
                x_val    = '0;
                m_pret   = 0;
                m_pstall = 0;
            end
        end else begin
            was_full = (mq.size() == D - 1);
            n = 0;
            while (n < W && mq.size() > n && mq[n].done) n++;
            if (mq.size() != 0 && n == 0 && m_pstall != 32'hFFFF_FFFF) m_pstall++;
            m_pret += longint'(n);
            x_en = '0;
            for (int k = 0; k < n; k++) begin
                e = mq.pop_front();
                x_en[k]            = 1'b1;
                x_dest[k*P +: P]   = e.dest;
                x_addr[k*AW +: AW] = e.tag;
                x_val[k*DW +: DW]  = e.val;
            end
            if (cmp_en) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].tag == cmp_rob_addr && !mq[i].done) begin
                        mq[i].done = 1'b1;
                        mq[i].dest = cmp_dest;
                        mq[i].val  = cmp_value;
                    end
                end
            end
            if (alloc_en && (!was_full || n > 0)) begin
                e.tag  = m_tail;
                e.done = 1'b0;
                e.dest = '0;
                e.val  = '0;
                mq.push_back(e);
                m_tail = (m_tail == AW'(D - 1)) ? AW'(1) : m_tail + AW'(1);
            end
        end
    endtask

    task automatic compare_outputs();
        chk("tail", 64'(alloc_rob_addr), 64'(m_tail));
        chk("full", 64'(rob_full), 64'(mq.size() == D - 1));
        chk("empty", 64'(rob_empty), 64'(mq.size() == 0));
        chk("ret_en", 64'(ret_en), 64'(x_en));
        for (int k = 0; k < W; k++) begin
            if (x_en[k]) begin
                chk("ret_dest", 64'(ret_dest[k*P +: P]), 64'(x_dest[k*P +: P]));
                chk("ret_addr", 64'(ret_rob_addr[k*AW +: AW]), 64'(x_addr[k*AW +: AW]));
                chk("ret_val", 64'(ret_value[k*DW +: DW]), 64'(x_val[k*DW +: DW]));
                $display("retire lane=%0d rob=%0d dest=%0d val=%h", k,
                         ret_rob_addr[k*AW +: AW], ret_dest[k*P +: P], ret_value[k*DW +: DW]);
            end
        end
`ifdef QU_RETIRE_PERF_CNT_EN
        chk("perf_ret", perf_retired_cnt, 64'(m_pret));
        chk("perf_stall", 64'(perf_stall_cnt), 64'(m_pstall));
`else
        chk("perf_ret", perf_retired_cnt, 64'd0);
        chk("perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, then check the outputs 1 time unit later.
    task automatic cyc(input bit r, input bit f, input bit a, input bit c,
                       input logic [AW-1:0] t, input logic [P-1:0] d, input logic [DW-1:0] v);
        rst          = r;
        flush        = f;
        alloc_en     = a;
        cmp_en       = c;
        cmp_rob_addr = t;
        cmp_dest     = d;
        cmp_value    = v;
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic alloc1();
        cyc(0, 0, 1, 0, '0, '0, '0);
    endtask

    task automatic cmp1(input logic [AW-1:0] t, input logic [P-1:0] d, input logic [DW-1:0] v);
        cyc(0, 0, 0, 1, t, d, v);
    endtask

    initial begin
        logic [AW-1:0] pend[$];
        logic [AW-1:0] tag;
        bit            r, f, a, c;

        rst = 1'b1; flush = 1'b0; alloc_en = 1'b0; cmp_en = 1'b0;
        cmp_rob_addr = '0; cmp_dest = '0; cmp_value = '0;
        mq.delete(); m_tail = 1; x_en = '0; x_dest = '0; x_addr = '0; x_val = '0;
        m_pret = 0; m_pstall = 0;

        // Reset state
        cyc(1, 0, 0, 0, '0, '0, '0);
        cyc(1, 0, 0, 0, '0, '0, '0);
        chk("rst_tail", 64'(alloc_rob_addr), 64'd1);
        chk("rst_empty", 64'(rob_empty), 64'd1);
        chk("rst_full", 64'(rob_full), 64'd0);
        chk("rst_ret_en", 64'(ret_en), 64'd0);
        chk("rst_ret_dest", 64'(ret_dest), 64'd0);

        // Dual retire: tags 2 and 1 complete out of order, then both leave in one cycle.
        alloc1(); alloc1(); alloc1();
        cmp1(4'd2, 6'd5, 32'hAA);
        cmp1(4'd1, 6'd4, 32'h55);
        idle();
        chk("w2_ret_en", 64'(ret_en), 64'h3);
        chk("w2_dest", 64'(ret_dest), {52'd0, 6'd5, 6'd4});
        chk("w2_addr", 64'(ret_rob_addr), {56'd0, 4'd2, 4'd1});
        idle();
        chk("w2_single", 64'(ret_en), 64'd0);
        chk("w2_tag3_left", 64'(rob_empty), 64'd0);

        // Fill to capacity. The tail wraps 15 -> 1 and skips 0.
        for (int i = 0; i < 14; i++) alloc1();
        chk("fill_full", 64'(rob_full), 64'd1);
        chk("fill_tail", 64'(alloc_rob_addr), 64'd3);
        alloc1();
        chk("full_drop_tail", 64'(alloc_rob_addr), 64'd3);
        cmp1(4'd3, 6'd9, 32'h1234_5678);
        alloc1();
        chk("full_alloc_ret", 64'(ret_en), 64'd1);
        chk("full_alloc_still", 64'(rob_full), 64'd1);
        chk("full_alloc_tail", 64'(alloc_rob_addr), 64'd4);

        // A writeback to a FREE tag is ignored.
        cyc(0, 1, 0, 0, '0, '0, '0);
        cmp1(4'd7, 6'd3, 32'hDEAD);
        idle(); idle();
        chk("free_cmp_ret", 64'(ret_en), 64'd0);
        chk("free_cmp_empty", 64'(rob_empty), 64'd1);

        // Three DONE entries behind a pending head, then a flush together with alloc_en.
        alloc1(); alloc1(); alloc1(); alloc1();
        cmp1(4'd2, 6'd1, 32'h2); cmp1(4'd3, 6'd2, 32'h3); cmp1(4'd4, 6'd3, 32'h4);
        cyc(0, 1, 1, 0, '0, '0, '0);
        chk("flush_empty", 64'(rob_empty), 64'd1);
        chk("flush_tail", 64'(alloc_rob_addr), 64'd1);
        chk("flush_ret", 64'(ret_en), 64'd0);
        idle();
        chk("flush_ret_next", 64'(ret_en), 64'd0);

        // A flush on the edge where a retire would have happened cancels it.
        alloc1();
        cmp1(4'd1, 6'd7, 32'h77);
        cyc(0, 1, 0, 0, '0, '0, '0);
        chk("flush_mid_ret", 64'(ret_en), 64'd0);

        // Perf: 4 retires and 3 head-stall cycles after a reset.
        cyc(1, 0, 0, 0, '0, '0, '0);
        alloc1();
        cyc(0, 0, 1, 1, 4'd1, 6'd10, 32'h10);
        cyc(0, 0, 1, 1, 4'd2, 6'd11, 32'h11);
        alloc1();
        idle();
        cmp1(4'd3, 6'd12, 32'h12);
        cmp1(4'd4, 6'd13, 32'h13);
        idle();
        idle();
`ifdef QU_RETIRE_PERF_CNT_EN
        chk("perf_ret4", perf_retired_cnt, 64'd4);
        chk("perf_stall3", 64'(perf_stall_cnt), 64'd3);
`else
        chk("perf_ret_off", perf_retired_cnt, 64'd0);
        chk("perf_stall_off", 64'(perf_stall_cnt), 64'd0);
`endif

        // Randomized traffic. Writebacks mostly target pending tags.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 999) == 0);
            f = ($urandom_range(0, 99) < 2);
            a = ($urandom_range(0, 99) < 55);
            c = ($urandom_range(0, 99) < 70);
            pend.delete();
            foreach (mq[j]) if (!mq[j].done) pend.push_back(mq[j].tag);
            if (pend.size() != 0 && $urandom_range(0, 9) < 8)
                tag = pend[$urandom_range(0, pend.size() - 1)];
            else
                tag = AW'($urandom_range(0, D - 1));
            cyc(r, f, a, c, tag, P'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
